// File: rtl/datapath_if.sv
// Observation bundle of the datapath: every architectural register plus the
// live bus value. The datapath drives it (master); monitors read it (slave).
interface datapath_if;
    logic [31:0] R1_q;
    logic [31:0] R2_q;
    logic [31:0] R3_q;
    logic [31:0] PC_q;
    logic [31:0] IR_q;
    logic [31:0] MAR_q;
    logic [31:0] MDR_q;
    logic [31:0] Y_q;
    logic [31:0] HI_q;
    logic [31:0] LO_q;
    logic [63:0] Z_q;
    logic [31:0] Bus_q;

    modport master (
        output R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q,
               Y_q, HI_q, LO_q, Z_q, Bus_q
    );

    modport slave (
        input  R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q,
               Y_q, HI_q, LO_q, Z_q, Bus_q
    );
endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: a prioritised 32-bit bus, general registers R1-R3,
// PC/IR/MAR/MDR, ALU operand register Y, a 64-bit result register Z feeding
// HI/LO, and a combinational signed divider. All state clears asynchronously
// when clear is low.
module datapath (
    input  logic        PCout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        LOin,
    input  logic        HIin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        DIV,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        Clock,
    input  logic [31:0] Mdatain,
    input  logic        clear,
    datapath_if.master  obs
);

    // Signed divide returning {remainder, quotient}. Magnitudes go through an
    // unsigned restoring divider and signs are reapplied afterwards, so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // Divide-by-zero and the single overflow case are resolved explicitly.
    function automatic logic [63:0] div_signed(input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [32:0] rem;
        logic [31:0] q_out;
        logic [31:0] r_out;
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        quo   = 32'd0;
        rem   = 33'd0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], mag_a[i]};
            if (rem >= {1'b0, mag_b}) begin
                rem    = rem - {1'b0, mag_b};
                quo[i] = 1'b1;
            end else begin
                quo[i] = 1'b0;
            end
        end
        q_out = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
        r_out = a[31] ? (~rem[31:0] + 32'd1) : rem[31:0];
        if (b == 32'd0) begin
            div_signed = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            div_signed = {32'd0, 32'h8000_0000};
        end else begin
            div_signed = {r_out, q_out};
        end
    endfunction

    logic [31:0] r_r1;
    logic [31:0] r_r2;
    logic [31:0] r_r3;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_z;

    logic [31:0] w_bus;
    logic [31:0] w_pc_next;
    logic [31:0] w_mdr_next;
    logic [63:0] w_alu;

    // Bus source mux: highest-priority asserted select wins, idle bus reads 0.
    always_comb begin
        w_bus = 32'd0;
        if (PCout) begin
            w_bus = r_pc;
        end else if (Zlowout) begin
            w_bus = r_z[31:0];
        end else if (Zhighout) begin
            w_bus = r_z[63:32];
        end else if (MDRout) begin
            w_bus = r_mdr;
        end else if (R2out) begin
            w_bus = r_r2;
        end else if (R3out) begin
            w_bus = r_r3;
        end else begin
            w_bus = 32'd0;
        end
    end

    // Next-value selection for PC (optional increment) and MDR (memory or bus).
    always_comb begin
        w_pc_next  = w_bus;
        w_mdr_next = w_bus;
        if (IncPC) begin
            w_pc_next = w_bus + 32'd1;
        end else begin
            w_pc_next = w_bus;
        end
        if (Read) begin
            w_mdr_next = Mdatain;
        end else begin
            w_mdr_next = w_bus;
        end
    end

    // ALU: A operand is Y, B operand is the bus; divide or zero-extended pass.
    always_comb begin
        w_alu = {32'd0, w_bus};
        if (DIV) begin
            w_alu = div_signed(r_y, w_bus);
        end else begin
            w_alu = {32'd0, w_bus};
        end
    end

    // General-purpose registers R1-R3 load the bus when enabled.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_r1 <= 32'd0;
            r_r2 <= 32'd0;
            r_r3 <= 32'd0;
        end else begin
            if (R1in) r_r1 <= w_bus;
            if (R2in) r_r2 <= w_bus;
            if (R3in) r_r3 <= w_bus;
        end
    end

    // Control-flow and memory-interface registers PC, IR, MAR, MDR.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_pc  <= 32'd0;
            r_ir  <= 32'd0;
            r_mar <= 32'd0;
            r_mdr <= 32'd0;
        end else begin
            if (PCin)  r_pc  <= w_pc_next;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (MDRin) r_mdr <= w_mdr_next;
        end
    end

    // Arithmetic registers: operand Y, result Z and the HI/LO result halves.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_y  <= 32'd0;
            r_z  <= 64'd0;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (Yin)  r_y  <= w_bus;
            if (Zin)  r_z  <= w_alu;
            if (HIin) r_hi <= w_bus;
            if (LOin) r_lo <= w_bus;
        end
    end

    assign obs.R1_q  = r_r1;
    assign obs.R2_q  = r_r2;
    assign obs.R3_q  = r_r3;
    assign obs.PC_q  = r_pc;
    assign obs.IR_q  = r_ir;
    assign obs.MAR_q = r_mar;
    assign obs.MDR_q = r_mdr;
    assign obs.Y_q   = r_y;
    assign obs.HI_q  = r_hi;
    assign obs.LO_q  = r_lo;
    assign obs.Z_q   = r_z;
    assign obs.Bus_q = w_bus;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the datapath: each step pushes the values it expects
// to see, and they are popped and compared once the DUT has produced them.
module tb_datapath;

    logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic        IncPC, Read, DIV, R1in, R2in, R3in;
    logic        Clock;
    logic [31:0] Mdatain;
    logic        clear;

    datapath_if u_if ();

    datapath u_dut (
        .PCout   (PCout),
        .Zlowout (Zlowout),
        .Zhighout(Zhighout),
        .MDRout  (MDRout),
        .R2out   (R2out),
        .R3out   (R3out),
        .MARin   (MARin),
        .Zin     (Zin),
        .PCin    (PCin),
        .MDRin   (MDRin),
        .IRin    (IRin),
        .Yin     (Yin),
        .LOin    (LOin),
        .HIin    (HIin),
        .IncPC   (IncPC),
        .Read    (Read),
        .DIV     (DIV),
        .R1in    (R1in),
        .R2in    (R2in),
        .R3in    (R3in),
        .Clock   (Clock),
        .Mdatain (Mdatain),
        .clear   (clear),
        .obs     (u_if)
    );

    localparam int SEL_R1 = 0, SEL_R2 = 1, SEL_R3 = 2, SEL_PC = 3, SEL_IR = 4,
                   SEL_MAR = 5, SEL_MDR = 6, SEL_Y = 7, SEL_HI = 8, SEL_LO = 9,
                   SEL_Z = 10, SEL_BUS = 11;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Free-running 100 MHz clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_obs(input int sel);
        case (sel)
            SEL_R1:  get_obs = {32'd0, u_if.R1_q};
            SEL_R2:  get_obs = {32'd0, u_if.R2_q};
            SEL_R3:  get_obs = {32'd0, u_if.R3_q};
            SEL_PC:  get_obs = {32'd0, u_if.PC_q};
            SEL_IR:  get_obs = {32'd0, u_if.IR_q};
            SEL_MAR: get_obs = {32'd0, u_if.MAR_q};
            SEL_MDR: get_obs = {32'd0, u_if.MDR_q};
            SEL_Y:   get_obs = {32'd0, u_if.Y_q};
            SEL_HI:  get_obs = {32'd0, u_if.HI_q};
            SEL_LO:  get_obs = {32'd0, u_if.LO_q};
            SEL_Z:   get_obs = u_if.Z_q;
            SEL_BUS: get_obs = {32'd0, u_if.Bus_q};
            default: get_obs = 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_value(e.tag, get_obs(e.sel), e.exp);
        end
    endtask

    task automatic clr_ctl();
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        R2out = 1'b0; R3out = 1'b0; MARin = 1'b0; Zin = 1'b0; PCin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; LOin = 1'b0; HIin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; DIV = 1'b0; R1in = 1'b0; R2in = 1'b0;
        R3in = 1'b0; Mdatain = 32'd0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clr_ctl();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clr_ctl(); Read = 1'b1; MDRin = 1'b1; Mdatain = v;
        tick();
    endtask

    task automatic push_all_zero(input string pfx);
        for (int s = 0; s <= SEL_Z; s++) push_exp($sformatf("%s_sel%0d", pfx, s), s, 64'd0);
    endtask

    // Load Y with a, put b on the bus through MDR, divide into Z, return Z.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1; tick();
        load_mdr(b);
        MDRout = 1'b1; DIV = 1'b1; Zin = 1'b1; tick();
    endtask

    logic [31:0] a_v, b_v, q_v, r_v;

    initial begin
        clr_ctl();
        clear = 1'b0;
        #12;
        push_all_zero("reset");
        drain();
        clear = 1'b1;
        @(posedge Clock); #1;

        // Instruction fetch from reset.
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; tick();
        push_exp("fetch_mar", SEL_MAR, 64'd0);
        push_exp("fetch_z", SEL_Z, 64'd0);
        drain();
        Zlowout = 1'b1; PCin = 1'b1; IncPC = 1'b1; Read = 1'b1; MDRin = 1'b1;
        Mdatain = 32'h1918_0000; tick();
        push_exp("fetch_pc", SEL_PC, 64'd1);
        push_exp("fetch_mdr", SEL_MDR, 64'h1918_0000);
        drain();
        MDRout = 1'b1; IRin = 1'b1; tick();
        push_exp("fetch_ir", SEL_IR, 64'h1918_0000);
        drain();

        // Register loads via MDR.
        load_mdr(32'd7);  MDRout = 1'b1; R2in = 1'b1; tick();
        load_mdr(32'd3);  MDRout = 1'b1; R3in = 1'b1; tick();
        load_mdr(32'h27); MDRout = 1'b1; R1in = 1'b1; tick();
        push_exp("ld_r2", SEL_R2, 64'd7);
        push_exp("ld_r3", SEL_R3, 64'd3);
        push_exp("ld_r1", SEL_R1, 64'h27);
        drain();

        // Bus priority, checked combinationally between edges.
        PCout = 1'b1; MDRout = 1'b1; #1;
        push_exp("bus_pc_over_mdr", SEL_BUS, 64'd1); drain();
        clr_ctl(); R2out = 1'b1; R3out = 1'b1; #1;
        push_exp("bus_r2_over_r3", SEL_BUS, 64'd7); drain();
        clr_ctl(); MDRout = 1'b1; R3out = 1'b1; #1;
        push_exp("bus_mdr_over_r3", SEL_BUS, 64'h27); drain();
        clr_ctl(); #1;
        push_exp("bus_idle", SEL_BUS, 64'd0); drain();
        @(posedge Clock); #1;

        // 7 / 3 through Y, Z, LO, HI.
        R2out = 1'b1; Yin = 1'b1; tick();
        R3out = 1'b1; DIV = 1'b1; Zin = 1'b1; tick();
        push_exp("div73_z", SEL_Z, 64'h0000_0001_0000_0002); drain();
        Zlowout = 1'b1; LOin = 1'b1; tick();
        Zhighout = 1'b1; HIin = 1'b1; tick();
        push_exp("div73_lo", SEL_LO, 64'd2);
        push_exp("div73_hi", SEL_HI, 64'd1);
        drain();

        // Idle bus into R1; IncPC alone; same register as source and sink.
        R1in = 1'b1; tick();
        push_exp("r1_idle_bus", SEL_R1, 64'd0); drain();
        IncPC = 1'b1; tick();
        push_exp("incpc_no_pcin", SEL_PC, 64'd1); drain();
        PCout = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick();
        push_exp("pc_self_inc", SEL_PC, 64'd2); drain();
        R2out = 1'b1; R2in = 1'b1; tick();
        push_exp("r2_self_hold", SEL_R2, 64'd7); drain();

        // Pass-through ALU.
        R3out = 1'b1; Zin = 1'b1; tick();
        push_exp("pass_z", SEL_Z, 64'h0000_0000_0000_0003); drain();

        // Negative dividend.
        do_div(32'hFFFF_FFF9, 32'd2);
        Zlowout = 1'b1; LOin = 1'b1; tick();
        Zhighout = 1'b1; HIin = 1'b1; tick();
        push_exp("neg7d2_lo", SEL_LO, 64'hFFFF_FFFD);
        push_exp("neg7d2_hi", SEL_HI, 64'hFFFF_FFFF);
        drain();

        // Divide by zero (bus idle = 0).
        load_mdr(32'd5);
        MDRout = 1'b1; Yin = 1'b1; tick();
        DIV = 1'b1; Zin = 1'b1; tick();
        Zlowout = 1'b1; LOin = 1'b1; tick();
        Zhighout = 1'b1; HIin = 1'b1; tick();
        push_exp("div0_lo", SEL_LO, 64'hFFFF_FFFF);
        push_exp("div0_hi", SEL_HI, 64'd5);
        drain();

        // Overflow case.
        do_div(32'h8000_0000, 32'hFFFF_FFFF);
        push_exp("ovf_z", SEL_Z, 64'h0000_0000_8000_0000); drain();

        // Random signed divides against a reference using SV signed semantics.
        for (int k = 0; k < 8; k++) begin
            a_v = (k % 2 == 0) ? $urandom : ($urandom_range(0, 200) - 32'd100);
            b_v = (k % 3 == 0) ? $urandom : ($urandom_range(1, 20));
            if (k % 4 == 1) b_v = ~b_v + 32'd1;
            if (b_v == 32'd0) b_v = 32'd1;
            if ((a_v == 32'h8000_0000) && (b_v == 32'hFFFF_FFFF)) a_v = 32'd1;
            q_v = $signed(a_v) / $signed(b_v);
            r_v = $signed(a_v) % $signed(b_v);
            do_div(a_v, b_v);
            push_exp($sformatf("rand_div%0d", k), SEL_Z, {r_v, q_v});
            drain();
        end

        // Asynchronous clear mid-operation.
        load_mdr(32'd9);
        MDRout = 1'b1; Yin = 1'b1; tick();
        R2out = 1'b1; DIV = 1'b1; Zin = 1'b1; tick();
        push_exp("pre_clr_z", SEL_Z, 64'h0000_0002_0000_0001); drain();
        #3;
        clear = 1'b0;
        #1;
        push_all_zero("async_clr");
        drain();
        Zlowout = 1'b1; LOin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h55;
        @(posedge Clock); #1;
        push_exp("held_clr_mdr", SEL_MDR, 64'd0);
        push_exp("held_clr_lo", SEL_LO, 64'd0);
        drain();
        #2;
        clear = 1'b1;
        @(posedge Clock); #1;
        push_exp("post_clr_lo", SEL_LO, 64'd0);
        push_exp("post_clr_mdr", SEL_MDR, 64'h55);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
